// File: rtl/memory_arbiter.sv
// Memory bus arbiter between instruction fetch and load/store data.
// One transaction at a time: IDLE picks a requester (round-robin on ties),
// ISSUE strobes the bus for one cycle, WAIT rides out bus_full, and RESP
// pulses the ack to the granted requester. If the bus stays busy too long,
// a busy-timeout aborts the transaction with err so the core cannot hang.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  input  logic [31:0] data_in_BUS,
  input  logic        bus_full,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_sel,
  output logic [31:0] address_out,
  output logic [31:0] data_out_BUS
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} grant_t;

  // The counter value seen on the last permitted busy WAIT cycle.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  grant_t      grant;
  grant_t      last_grant;
  grant_t      pick;
  logic        pick_valid;
  logic        lat_we;
  logic [15:0] wait_count;

  // Choose the next requester; on a tie, serve whoever did not go last.
  always_comb begin
    pick_valid = i_req | d_req;
    pick       = FETCH;
    if (d_req && (!i_req || last_grant == FETCH)) begin
      pick = DATA;
    end
  end

  // Transaction FSM with every output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= FETCH;
      last_grant   <= FETCH;
      lat_we       <= 1'b0;
      wait_count   <= 16'd0;
      i_ack        <= 1'b0;
      i_data       <= 32'd0;
      d_ack        <= 1'b0;
      d_rdata      <= 32'd0;
      err          <= 1'b0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
      bus_sel      <= 4'd0;
      address_out  <= 32'd0;
      data_out_BUS <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= ISSUE;
            if (pick == DATA) begin
              lat_we       <= d_we;
              address_out  <= d_addr;
              bus_sel      <= d_sel;
              bus_read     <= ~d_we;
              bus_write    <= d_we;
              data_out_BUS <= d_we ? d_wdata : 32'd0;
            end else begin
              lat_we       <= 1'b0;
              address_out  <= i_addr;
              bus_sel      <= 4'b1111;
              bus_read     <= 1'b1;
              bus_write    <= 1'b0;
              data_out_BUS <= 32'd0;
            end
          end
        end
        ISSUE: begin
          bus_read   <= 1'b0;
          bus_write  <= 1'b0;
          wait_count <= 16'd0;
          state      <= WAIT;
        end
        WAIT: begin
          if (!bus_full || wait_count == TIMEOUT_LAST) begin
            state        <= RESP;
            address_out  <= 32'd0;
            bus_sel      <= 4'd0;
            data_out_BUS <= 32'd0;
            err          <= bus_full;
            if (grant == DATA) begin
              d_ack   <= 1'b1;
              d_rdata <= (bus_full || lat_we) ? 32'd0 : data_in_BUS;
            end else begin
              i_ack  <= 1'b1;
              i_data <= bus_full ? 32'd0 : data_in_BUS;
            end
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end
        RESP: begin
          i_ack   <= 1'b0;
          i_data  <= 32'd0;
          d_ack   <= 1'b0;
          d_rdata <= 32'd0;
          err     <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter. A second instance with a short
// busy-timeout shares the same stimulus and is only checked in the
// timeout scenario.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] data_in_BUS;
  logic        bus_full;

  logic        i_ack, d_ack, err, bus_read, bus_write;
  logic [31:0] i_data, d_rdata, address_out, data_out_BUS;
  logic [3:0]  bus_sel;

  logic        t_i_ack, t_d_ack, t_err, t_bus_read, t_bus_write;
  logic [31:0] t_i_data, t_d_rdata, t_address_out, t_data_out_BUS;
  logic [3:0]  t_bus_sel;

  int checks = 0;
  int passes = 0;

  memory_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .data_in_BUS(data_in_BUS), .bus_full(bus_full),
    .bus_read(bus_read), .bus_write(bus_write), .bus_sel(bus_sel),
    .address_out(address_out), .data_out_BUS(data_out_BUS)
  );

  memory_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(t_i_ack), .i_data(t_i_data),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(t_d_ack), .d_rdata(t_d_rdata), .err(t_err),
    .data_in_BUS(data_in_BUS), .bus_full(bus_full),
    .bus_read(t_bus_read), .bus_write(t_bus_write), .bus_sel(t_bus_sel),
    .address_out(t_address_out), .data_out_BUS(t_data_out_BUS)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [3:0] ds, input logic [31:0] da,
                               input logic [31:0] dwd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_sel   = ds;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    bus_full    = 1'b0;
    data_in_BUS = 32'd0;
    waitCycles(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #1;
    resetDut();

    // Reset state: every output low.
    checkOutput("rst_i_ack",    32'(i_ack), 32'd0);
    checkOutput("rst_d_ack",    32'(d_ack), 32'd0);
    checkOutput("rst_bus_read", 32'(bus_read), 32'd0);
    checkOutput("rst_addr",     address_out, 32'd0);

    // Zero-wait fetch.
    data_in_BUS = 32'h0041_0083;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    waitCycles(1);
    checkOutput("f_bus_read", 32'(bus_read), 32'd1);
    checkOutput("f_addr",     address_out, 32'h10);
    checkOutput("f_sel",      32'(bus_sel), 32'hF);
    waitCycles(1);
    checkOutput("f_wait_read", 32'(bus_read), 32'd0);
    checkOutput("f_wait_ack",  32'(i_ack), 32'd0);
    waitCycles(1);
    checkOutput("f_ack",  32'(i_ack), 32'd1);
    checkOutput("f_data", i_data, 32'h0041_0083);
    checkOutput("f_err",  32'(err), 32'd0);
    i_req = 1'b0;
    waitCycles(1);
    checkOutput("f_ack_drop", 32'(i_ack), 32'd0);
    checkOutput("f_data_drop", i_data, 32'd0);

    // Store with four busy WAIT cycles.
    data_in_BUS = 32'h1234_5678;
    bus_full    = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    waitCycles(1);
    checkOutput("s_bus_write", 32'(bus_write), 32'd1);
    checkOutput("s_bus_read",  32'(bus_read), 32'd0);
    checkOutput("s_dout",      data_out_BUS, 32'hDEAD_BEEF);
    checkOutput("s_sel",       32'(bus_sel), 32'h3);
    checkOutput("s_addr",      address_out, 32'h100);
    for (int c = 2; c <= 5; c++) begin
      waitCycles(1);
      checkOutput($sformatf("s_hold_dout_c%0d", c), data_out_BUS, 32'hDEAD_BEEF);
      checkOutput($sformatf("s_hold_write_c%0d", c), 32'(bus_write), 32'd0);
    end
    waitCycles(1);
    bus_full = 1'b0;
    checkOutput("s_c6_ack", 32'(d_ack), 32'd0);
    waitCycles(1);
    checkOutput("s_ack",   32'(d_ack), 32'd1);
    checkOutput("s_rdata", d_rdata, 32'd0);
    checkOutput("s_err",   32'(err), 32'd0);
    d_req = 1'b0;

    // Both requesters held from reset: DATA, FETCH, DATA, FETCH.
    rst = 1'b1;
    data_in_BUS = 32'hA5A5_0000;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h80, 32'd0);
    waitCycles(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      waitCycles(1);
      checkOutput($sformatf("rr_addr_%0d", k), address_out,
                  (k % 2 == 0) ? 32'h80 : 32'h40);
      waitCycles(2);
      checkOutput($sformatf("rr_d_ack_%0d", k), 32'(d_ack),
                  (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_i_ack_%0d", k), 32'(i_ack),
                  (k % 2 == 0) ? 32'd0 : 32'd1);
      waitCycles(1);
    end

    // Timeout with the bus stuck busy (short-timeout instance).
    resetDut();
    bus_full = 1'b1;
    data_in_BUS = 32'h7777_7777;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h180, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      waitCycles(1);
      checkOutput($sformatf("to_no_ack_c%0d", c), 32'(t_d_ack), 32'd0);
    end
    waitCycles(1);
    checkOutput("to_ack",   32'(t_d_ack), 32'd1);
    checkOutput("to_err",   32'(t_err), 32'd1);
    checkOutput("to_rdata", t_d_rdata, 32'd0);
    bus_full = 1'b0;
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    waitCycles(1);
    checkOutput("to_err_clear", 32'(t_err), 32'd0);
    waitCycles(1);
    checkOutput("to_next_read", 32'(t_bus_read), 32'd1);
    checkOutput("to_next_addr", t_address_out, 32'h20);
    waitCycles(2);
    checkOutput("to_next_ack",  32'(t_i_ack), 32'd1);
    checkOutput("to_next_data", t_i_data, 32'h7777_7777);
    i_req = 1'b0;

    // Reset in the middle of a load, then a fresh load.
    resetDut();
    bus_full = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h300, 32'd0);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("mr_d_ack", 32'(d_ack), 32'd0);
    checkOutput("mr_addr",  address_out, 32'd0);
    checkOutput("mr_sel",   32'(bus_sel), 32'd0);
    rst = 1'b0;
    bus_full = 1'b0;
    data_in_BUS = 32'hCAFE_0001;
    waitCycles(1);
    checkOutput("mr_read", 32'(bus_read), 32'd1);
    checkOutput("mr_addr2", address_out, 32'h300);
    waitCycles(2);
    checkOutput("mr_ack",   32'(d_ack), 32'd1);
    checkOutput("mr_rdata", d_rdata, 32'hCAFE_0001);
    d_req = 1'b0;

    // Fetch raised during a load's WAIT is held off until the next IDLE.
    resetDut();
    bus_full = 1'b1;
    data_in_BUS = 32'h0BAD_F00D;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h200, 32'd0);
    waitCycles(2);
    i_req  = 1'b1;
    i_addr = 32'h44;
    waitCycles(1);
    bus_full = 1'b0;
    checkOutput("lw_hold_addr", address_out, 32'h200);
    checkOutput("lw_hold_read", 32'(bus_read), 32'd0);
    waitCycles(1);
    checkOutput("lw_d_ack",  32'(d_ack), 32'd1);
    checkOutput("lw_i_ack",  32'(i_ack), 32'd0);
    checkOutput("lw_rdata",  d_rdata, 32'h0BAD_F00D);
    d_req = 1'b0;
    waitCycles(1);
    checkOutput("lw_idle_read", 32'(bus_read), 32'd0);
    waitCycles(1);
    checkOutput("lw_f_read", 32'(bus_read), 32'd1);
    checkOutput("lw_f_addr", address_out, 32'h44);
    waitCycles(2);
    checkOutput("lw_f_ack",  32'(i_ack), 32'd1);
    checkOutput("lw_f_data", i_data, 32'h0BAD_F00D);
    i_req = 1'b0;
    waitCycles(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
